// File: rtl/uart_pkg.sv
// Shared constants, line-echo FSM encoding and byte helpers for the UART loopback path.
//   ASCII_CR / ASCII_LF  : line-ending bytes appended to every echoed line
//   ASCII_CASE_OFS       : distance between lower- and upper-case ASCII letters
//   echo_state_e         : 2-bit state encoding for uart_line_echo
//   to_upper()           : maps 'a'..'z' to 'A'..'Z', passes every other byte through
package uart_pkg;

  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  typedef enum logic [1:0] {
    RECV    = 2'd0,
    SEND    = 2'd1,
    SEND_CR = 2'd2,
    SEND_LF = 2'd3
  } echo_state_e;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) begin
      return b - ASCII_CASE_OFS;
    end
    return b;
  endfunction

endpackage

// File: rtl/line_buf_ram.sv
// Simple dual-port line buffer: synchronous write, registered read (one-cycle latency).
// Contents carry no reset so the array maps onto block/distributed SRAM.
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write byte
//   i_raddr  in   read address, sampled every clock
//   o_rdata  out  byte at i_raddr from the previous clock
module line_buf_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_line_echo.sv
// Line-buffering echo stage between uart_rx and uart_tx. Bytes are stored until the
// terminator arrives, then the stored line is replayed followed by CR LF.
// Optional build macro: UART_LINE_UPPERCASE_EN (replayed letters a-z go out upper-case).
//   clk, rst              clock, asynchronous active-high reset
//   rx_data/_valid/_ready  byte stream from uart_rx (valid/ready)
//   tx_data/_valid/_ready  byte stream to uart_tx (valid/ready)
//   line_len               bytes stored in the current line
//   overflow               sticky: a byte was dropped in the current line
module uart_line_echo
  import uart_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 64,
  parameter  logic [7:0]  TERM    = 8'h0D,
  localparam int unsigned ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_data_valid,
  output logic            rx_data_ready,
  output logic [7:0]      tx_data,
  output logic            tx_data_valid,
  input  logic            tx_data_ready,
  output logic [ADDR_W:0] line_len,
  output logic            overflow
);

  localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  echo_state_e       r_state, w_state_nx;
  logic [ADDR_W:0]   r_len, w_len_nx;
  logic              r_ovf, w_ovf_nx;
  logic [ADDR_W-1:0] r_rd_ptr, w_rd_ptr_nx;
  logic [7:0]        r_tx_data, w_tx_data_nx;
  logic              r_tx_valid, w_tx_valid_nx;
  logic              r_rx_ready, w_rx_ready_nx;
  logic              w_we;
  logic [7:0]        w_ram_q;
  logic [7:0]        w_tx_byte;
  logic              w_rx_fire;
  logic              w_tx_fire;
  logic              w_last_byte;

  // Read address follows the next pointer so the refetched byte is ready one cycle later.
  line_buf_ram #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_len[ADDR_W-1:0]),
    .i_wdata (rx_data),
    .i_raddr (w_rd_ptr_nx),
    .o_rdata (w_ram_q)
  );

`ifdef UART_LINE_UPPERCASE_EN
  assign w_tx_byte = to_upper(w_ram_q);
`else
  assign w_tx_byte = w_ram_q;
`endif

  assign w_rx_fire   = rx_data_valid && r_rx_ready;
  assign w_tx_fire   = r_tx_valid && tx_data_ready;
  assign w_last_byte = ((ADDR_W+1)'(r_rd_ptr) == (r_len - LEN_ONE));

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RECV;
      r_len      <= '0;
      r_ovf      <= 1'b0;
      r_rd_ptr   <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_rx_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_len      <= w_len_nx;
      r_ovf      <= w_ovf_nx;
      r_rd_ptr   <= w_rd_ptr_nx;
      r_tx_data  <= w_tx_data_nx;
      r_tx_valid <= w_tx_valid_nx;
      r_rx_ready <= w_rx_ready_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx    = r_state;
    w_len_nx      = r_len;
    w_ovf_nx      = r_ovf;
    w_rd_ptr_nx   = r_rd_ptr;
    w_tx_data_nx  = r_tx_data;
    w_tx_valid_nx = r_tx_valid;
    w_rx_ready_nx = r_rx_ready;
    w_we          = 1'b0;

    case (r_state)
      RECV: begin
        w_rx_ready_nx = 1'b1;
        w_tx_valid_nx = 1'b0;
        if (w_rx_fire) begin
          if (rx_data == TERM) begin
            w_rx_ready_nx = 1'b0;
            if (r_len != '0) begin
              w_state_nx  = SEND;
              w_rd_ptr_nx = '0;
            end else begin
              // Empty line: CR is presented straight away.
              w_state_nx    = SEND_CR;
              w_tx_data_nx  = ASCII_CR;
              w_tx_valid_nx = 1'b1;
            end
          end else if (rx_data == ASCII_LF) begin
            w_len_nx = r_len;
          end else if (r_len < LEN_MAX) begin
            w_we     = 1'b1;
            w_len_nx = r_len + LEN_ONE;
          end else begin
            w_ovf_nx = 1'b1;
          end
        end
      end

      SEND: begin
        w_rx_ready_nx = 1'b0;
        if (!r_tx_valid) begin
          // Refetch cycle: RAM output now holds buf[rd_ptr].
          w_tx_data_nx  = w_tx_byte;
          w_tx_valid_nx = 1'b1;
        end else if (w_tx_fire) begin
          if (w_last_byte) begin
            w_state_nx    = SEND_CR;
            w_tx_data_nx  = ASCII_CR;
            w_tx_valid_nx = 1'b1;
          end else begin
            w_rd_ptr_nx   = r_rd_ptr + PTR_ONE;
            w_tx_valid_nx = 1'b0;
          end
        end
      end

      SEND_CR: begin
        w_rx_ready_nx = 1'b0;
        w_tx_valid_nx = 1'b1;
        if (w_tx_fire) begin
          w_state_nx   = SEND_LF;
          w_tx_data_nx = ASCII_LF;
        end
      end

      SEND_LF: begin
        w_rx_ready_nx = 1'b0;
        w_tx_valid_nx = 1'b1;
        if (w_tx_fire) begin
          w_state_nx    = RECV;
          w_len_nx      = '0;
          w_ovf_nx      = 1'b0;
          w_tx_valid_nx = 1'b0;
          w_rx_ready_nx = 1'b1;
        end
      end
    endcase
  end

  assign rx_data_ready = r_rx_ready;
  assign tx_data       = r_tx_data;
  assign tx_data_valid = r_tx_valid;
  assign line_len      = r_len;
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_uart_line_echo.sv
// Directed bench for uart_line_echo (MAX_LEN=4): table of lines with expected echoes,
// plus hand-written sequences for reset values and reset during replay.
module tb_uart_line_echo;

  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN) + 1;

  logic             clk;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_data_valid;
  logic             rx_data_ready;
  logic [7:0]       tx_data;
  logic             tx_data_valid;
  logic             tx_data_ready;
  logic [LEN_W-1:0] line_len;
  logic             overflow;

  uart_line_echo #(
    .MAX_LEN (MAX_LEN),
    .TERM    (8'h0D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .line_len      (line_len),
    .overflow      (overflow)
  );

  typedef struct {
    int          n_in;
    logic [63:0] in_b;   // byte i at [8*i +: 8], terminator last
    int          stall;  // 0: always ready, 1: ready one cycle in three
    int          n_exp;
    logic [63:0] exp_b;
  } vec_t;

  vec_t       vt [6];
  int         n_vec = 0;
  int         n_err = 0;
  int         g_stall = 0;
  int         stall_cnt = 0;
  logic [7:0] q_tx [$];
  logic       p_valid = 1'b0;
  logic       p_ready = 1'b0;
  logic [7:0] p_data = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Sink side: drives tx_data_ready, records transfers, checks hold-while-stalled.
  always @(negedge clk) begin
    if (rst) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && !p_ready) begin
        chk("hold_valid", 32'(tx_data_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(p_data));
      end
      tx_data_ready = (g_stall == 0) ? 1'b1 : (stall_cnt % 3 == 0);
      stall_cnt++;
      if (tx_data_valid && tx_data_ready) q_tx.push_back(tx_data);
      p_valid = tx_data_valid;
      p_ready = tx_data_ready;
      p_data  = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    rx_data       = b;
    rx_data_valid = 1'b1;
    while (!rx_data_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rx_data_valid = 1'b0;
  endtask

  task automatic run_line(input vec_t v);
    int         m_len = 0;
    logic       m_ovf = 1'b0;
    logic       leak  = 1'b0;
    int         t     = 0;
    logic [7:0] b;
    q_tx.delete();
    g_stall = v.stall;
    for (int i = 0; i < v.n_in - 1; i++) begin
      b = v.in_b[8*i +: 8];
      send_byte(b);
      if (b != 8'h0A) begin
        if (m_len < int'(MAX_LEN)) m_len++;
        else m_ovf = 1'b1;
      end
      chk("line_len", 32'(line_len), 32'(m_len));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
    b = v.in_b[8*(v.n_in-1) +: 8];
    send_byte(b);
    chk("rx_ready_after_term", 32'(rx_data_ready), 32'd0);
    chk("valid_term_plus1", 32'(tx_data_valid), 32'(v.n_exp == 2));
    if (v.n_exp != 2) begin
      @(negedge clk);
      chk("valid_term_plus2", 32'(tx_data_valid), 32'd1);
    end
    while (q_tx.size() < v.n_exp && t < 300) begin
      if (rx_data_ready) leak = 1'b1;
      @(negedge clk);
      t++;
    end
    chk("tx_count", 32'(q_tx.size()), 32'(v.n_exp));
    chk("rx_ready_low_during_send", 32'(leak), 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < v.n_exp; i++) begin
      if (i < q_tx.size()) chk("tx_byte", 32'(q_tx[i]), 32'(v.exp_b[8*i +: 8]));
      else chk("tx_byte_missing", 32'd0, 32'd1);
    end
    chk("end_line_len", 32'(line_len), 32'd0);
    chk("end_overflow", 32'(overflow), 32'd0);
    chk("end_rx_ready", 32'(rx_data_ready), 32'd1);
    chk("end_tx_valid", 32'(tx_data_valid), 32'd0);
  endtask

  initial begin
    int t;
    vt[0] = '{4, 64'h0000_0000_0D63_6261, 0, 5, 64'h0000_000A_0D63_6261};
    vt[1] = '{1, 64'h0000_0000_0000_000D, 0, 2, 64'h0000_0000_0000_0A0D};
    vt[2] = '{7, 64'h000D_6665_6463_6261, 0, 6, 64'h0000_0A0D_6463_6261};
    vt[3] = '{4, 64'h0000_0000_0D0A_6968, 1, 4, 64'h0000_0000_0A0D_6968};
`ifdef UART_LINE_UPPERCASE_EN
    vt[4] = '{4, 64'h0000_0000_0D31_5A61, 0, 5, 64'h0000_000A_0D31_5A41};
`else
    vt[4] = '{4, 64'h0000_0000_0D31_5A61, 0, 5, 64'h0000_000A_0D31_5A61};
`endif
    vt[5] = '{2, 64'h0000_0000_0000_0D71, 0, 3, 64'h0000_0000_000A_0D71};

    rst           = 1'b1;
    rx_data       = 8'h00;
    rx_data_valid = 1'b0;
    tx_data_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 32'(rx_data_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_line_len", 32'(line_len), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) run_line(vt[v]);

    // Reset while "xyz" is being replayed, after 'x' has gone out.
    g_stall = 0;
    q_tx.delete();
    send_byte(8'h78);
    send_byte(8'h79);
    send_byte(8'h7A);
    send_byte(8'h0D);
    t = 0;
    while (q_tx.size() < 1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q_tx.size() > 0) chk("rst_seq_first_byte", 32'(q_tx[0]), 32'h78);
    else chk("rst_seq_first_byte_missing", 32'd0, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midsend_rst_tx_valid", 32'(tx_data_valid), 32'd0);
    chk("midsend_rst_rx_ready", 32'(rx_data_ready), 32'd1);
    chk("midsend_rst_line_len", 32'(line_len), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tx_valid", 32'(tx_data_valid), 32'd0);
    chk("post_rst_rx_ready", 32'(rx_data_ready), 32'd1);
    chk("post_rst_line_len", 32'(line_len), 32'd0);
    run_line(vt[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

endmodule
